// File: rtl/mc_ctrl_pkg.sv
// Shared MIPS definitions for the multi-cycle controller and the datapath ALU:
// opcode/funct values, ALU operation codes, FSM state and instruction class
// encodings, and the decoder result record.
package mc_ctrl_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  // ALU operation codes shared with the datapath ALU
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_OR  = 3'b010,
    ALU_LUI = 3'b011   // B << 16
  } alu_op_e;

  // Controller FSM states
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // Instruction classes that steer the sequencing
  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_R    = 3'd1,
    C_ORI  = 3'd2,
    C_LUI  = 3'd3,
    C_LW   = 3'd4,
    C_SW   = 3'd5,
    C_BEQ  = 3'd6,
    C_J    = 3'd7
  } instr_class_e;

  // Decoder result
  typedef struct packed {
    logic         legal;
    instr_class_e cls;
    alu_op_e      alu_ct;
    logic         ext_op;
  } dec_t;

endpackage

// File: rtl/mc_dec.sv
// Combinational instruction decoder: latched op/fn -> {legal, class, ALUct, ExtOp}.
// Anything not in the supported subset is reported as illegal.
module mc_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output dec_t       dec
);

  // Table lookup of the supported instruction subset
  always_comb begin
    // NOTE: every field gets a default first so no path through the case can
    // leave a signal unassigned and infer a latch.
    dec.legal  = 1'b0;
    dec.cls    = C_NONE;
    dec.alu_ct = ALU_ADD;
    dec.ext_op = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_ADDU) begin
          dec.legal  = 1'b1;
          dec.cls    = C_R;
          dec.alu_ct = ALU_ADD;
        end else if (fn == FN_SUBU) begin
          dec.legal  = 1'b1;
          dec.cls    = C_R;
          dec.alu_ct = ALU_SUB;
        end
      end
      OP_ORI: begin
        dec.legal  = 1'b1;
        dec.cls    = C_ORI;
        dec.alu_ct = ALU_OR;
      end
      OP_LUI: begin
        dec.legal  = 1'b1;
        dec.cls    = C_LUI;
        dec.alu_ct = ALU_LUI;
      end
      OP_LW: begin
        dec.legal  = 1'b1;
        dec.cls    = C_LW;
        dec.ext_op = 1'b1;
      end
      OP_SW: begin
        dec.legal  = 1'b1;
        dec.cls    = C_SW;
        dec.ext_op = 1'b1;
      end
      OP_BEQ: begin
        dec.legal  = 1'b1;
        dec.cls    = C_BEQ;
        dec.alu_ct = ALU_SUB;
        dec.ext_op = 1'b1;   // branch offset is signed
      end
      OP_J: begin
        dec.legal  = 1'b1;
        dec.cls    = C_J;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing with
// a req/rdy data-memory handshake and an absorbing HALT on illegal opcodes.
// Optional perf counters are enabled by defining MC_CTRL_PERF_EN; without it
// cyc_cnt/ret_cnt are tied to zero and no counter flops exist.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             mem_rdy,
  output logic             pc_en,
  output logic             RegDst,
  output logic             ALUSr,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             mem_req,
  output logic             nPC_sel,
  output logic             jump,
  output logic             ExtOp,
  output logic [2:0]       ALUct,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] fn_q, fn_d;
  dec_t       dec;
  logic       alu_src;

  // Only opcode and funct fields matter to the controller.
  logic unused_instr;
  assign unused_instr = ^instr[25:6];

  mc_dec u_dec (
    .op  (op_q),
    .fn  (fn_q),
    .dec (dec)
  );

  // Immediate-operand classes feed the ALU from the extender.
  assign alu_src = (dec.cls == C_ORI) || (dec.cls == C_LUI) ||
                   (dec.cls == C_LW)  || (dec.cls == C_SW);

  // State register and latched op/fn, synchronous active-high reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from values sampled at the same edge.
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
    end
  end

  // Next-state and control-strobe generation from state + latched op/fn
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    fn_d     = fn_q;
    pc_en    = 1'b0;
    RegDst   = 1'b0;
    ALUSr    = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    mem_req  = 1'b0;
    nPC_sel  = 1'b0;
    jump     = 1'b0;
    ExtOp    = 1'b0;
    ALUct    = ALU_ADD;
    halted   = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        op_d    = instr[31:26];
        fn_d    = instr[5:0];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = dec.legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        ALUct = dec.alu_ct;
        ExtOp = dec.ext_op;
        ALUSr = alu_src;
        case (dec.cls)
          C_BEQ: begin
            nPC_sel = 1'b1;
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
          C_J: begin
            jump    = 1'b1;
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
          C_LW, C_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        ALUSr   = 1'b1;
        ExtOp   = 1'b1;
        ALUct   = ALU_ADD;
        if (mem_rdy) begin
          if (dec.cls == C_SW) begin
            MemWrite = 1'b1;
            pc_en    = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d  = S_WB;
          end
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        pc_en    = 1'b1;
        state_d  = S_FETCH;
        RegDst   = (dec.cls == C_R);
        if (dec.cls == C_LW) begin
          MemtoReg = 1'b1;
        end else begin
          // Keep the ALU result stable while it is written back.
          ALUct = dec.alu_ct;
          ExtOp = dec.ext_op;
          ALUSr = alu_src;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // A reset cycle must never issue a partial write or PC update.
    if (reset) begin
      pc_en    = 1'b0;
      RegDst   = 1'b0;
      ALUSr    = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      mem_req  = 1'b0;
      nPC_sel  = 1'b0;
      jump     = 1'b0;
      ExtOp    = 1'b0;
      ALUct    = ALU_ADD;
      halted   = 1'b0;
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

  // Counter increments; both freeze while halted and wrap naturally
  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    ret_cnt_d = ret_cnt_q;
    if (state_q != S_HALT) begin
      cyc_cnt_d = cyc_cnt_q + 1'b1;
      if (pc_en) ret_cnt_d = ret_cnt_q + 1'b1;
    end
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
`else
  assign cyc_cnt = '0;
  assign ret_cnt = '0;
`endif

endmodule
